// File: rtl/pipe_issue_sched_if.sv
// ---------------------------------------------------------------------------
// pipe_issue_sched_if
//
// Request channel from one instruction requester into the issue scheduler.
// Each requester (A and B) gets its own instance of this interface.
//
//   valid  requester -> scheduler  an op is being presented
//   rs1    requester -> scheduler  first source register
//   rs2    requester -> scheduler  second source register
//   rd     requester -> scheduler  destination register
//   func   requester -> scheduler  function code (12..15 are illegal)
//   addr   requester -> scheduler  store address
//   ready  scheduler -> requester  op is consumed at the coming clock edge
//
// The requester holds valid and the payload stable until it sees ready.
// ---------------------------------------------------------------------------
interface pipe_issue_sched_if;
  logic       valid;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic [3:0] rd;
  logic [3:0] func;
  logic [7:0] addr;
  logic       ready;

  // The requester side drives the op and watches ready
  modport master (
    output valid, rs1, rs2, rd, func, addr,
    input  ready
  );

  // The scheduler side samples the op and answers with ready
  modport slave (
    input  valid, rs1, rs2, rd, func, addr,
    output ready
  );
endinterface

// File: rtl/pipe_issue_sched.sv
// ---------------------------------------------------------------------------
// pipe_issue_sched
//
// Issue scheduler for the 4-stage ALU pipeline (register read, execute,
// regbank writeback, memory store). Two requesters compete for a single
// issue slot per cycle with round-robin priority. A 16-entry scoreboard of
// 3-bit countdown counters keeps a reader of a register from issuing until
// the producing op has had WB_LAT cycles to reach writeback. Illegal
// function codes (12..15) are consumed and flagged instead of being issued.
//
// Ports:
//   clk1_i       pipeline clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   hold_i       freezes acceptance (the scoreboard keeps counting down)
//   reqA, reqB   request channels (slave side), ready is combinational
//   iss_valid_o  issue slot holds a new op this cycle (registered)
//   iss_rs1_o, iss_rs2_o, iss_rd_o, iss_func_o, iss_addr_o
//                issued op fields, held when no op is issued
//   iss_src_o    0 = op came from A, 1 = op came from B
//   err_func_o   one-cycle pulse after an illegal func is consumed
//   issue_cnt_o  total issued ops, wraps at 16 bits
//   stall_cnt_o  cycles with a valid request and no acceptance, wraps
//
// Parameter:
//   WB_LAT       edges between an issue and the earliest issue of an op
//                reading its rd, legal range 1..7
// ---------------------------------------------------------------------------
module pipe_issue_sched #(
  parameter int unsigned WB_LAT = 3
) (
  input  logic              clk1_i,
  input  logic              rst_i,
  input  logic              hold_i,
  pipe_issue_sched_if.slave reqA,
  pipe_issue_sched_if.slave reqB,
  output logic              iss_valid_o,
  output logic [3:0]        iss_rs1_o,
  output logic [3:0]        iss_rs2_o,
  output logic [3:0]        iss_rd_o,
  output logic [3:0]        iss_func_o,
  output logic [7:0]        iss_addr_o,
  output logic              iss_src_o,
  output logic              err_func_o,
  output logic [15:0]       issue_cnt_o,
  output logic [15:0]       stall_cnt_o
);

  // Round-robin pointer values: which side wins when both are eligible
  localparam logic [0:0] PRIO_A = 1'b0;
  localparam logic [0:0] PRIO_B = 1'b1;

  localparam logic [2:0] LOAD_VAL = 3'(WB_LAT);

  // Source usage by function code
  function automatic logic readsRs1(input logic [3:0] func);
    logic r;
    case (func)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11: r = 1'b1;
      default:                                                      r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic readsRs2(input logic [3:0] func);
    logic r;
    case (func)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic isIllegal(input logic [3:0] func);
    return func >= 4'd12;
  endfunction

  // A counter of 1 reaches zero at the very edge that would accept the
  // reader, so the register is already free for that edge. This is what
  // lets a dependent op issue exactly WB_LAT edges after its producer.
  function automatic logic srcFree(input logic [2:0] cnt);
    return cnt <= 3'd1;
  endfunction

  // Scoreboard and slot state
  logic [15:0][2:0] sbCnt_q, sbCnt_d;
  logic [0:0]       prio_q, prio_d;
  logic             issValid_q, issValid_d;
  logic [3:0]       issRs1_q, issRs1_d;
  logic [3:0]       issRs2_q, issRs2_d;
  logic [3:0]       issRd_q, issRd_d;
  logic [3:0]       issFunc_q, issFunc_d;
  logic [7:0]       issAddr_q, issAddr_d;
  logic             issSrc_q, issSrc_d;
  logic             errFunc_q, errFunc_d;
  logic [15:0]      issueCnt_q, issueCnt_d;
  logic [15:0]      stallCnt_q, stallCnt_d;

  // Arbitration results and the winning op
  logic       aEligible, bEligible;
  logic       winA, winB;
  logic       accept, selIllegal, issueNow, stallNow;
  logic [3:0] selRs1, selRs2, selRd, selFunc;
  logic [7:0] selAddr;

  // Eligibility: an illegal op is always eligible so it can be drained and
  // flagged; a legal op needs every source it actually reads to be free.
  // Nothing is eligible during hold or reset.
  always_comb begin
    aEligible = reqA.valid && !hold_i && !rst_i &&
                (isIllegal(reqA.func) ||
                 ((!readsRs1(reqA.func) || srcFree(sbCnt_q[reqA.rs1])) &&
                  (!readsRs2(reqA.func) || srcFree(sbCnt_q[reqA.rs2]))));
    bEligible = reqB.valid && !hold_i && !rst_i &&
                (isIllegal(reqB.func) ||
                 ((!readsRs1(reqB.func) || srcFree(sbCnt_q[reqB.rs1])) &&
                  (!readsRs2(reqB.func) || srcFree(sbCnt_q[reqB.rs2]))));
  end

  // Round-robin pick: the pointer only matters when both sides are
  // eligible, so a blocked side never holds up the other one. The two
  // win terms are mutually exclusive by construction.
  always_comb begin
    winA = aEligible && (!bEligible || prio_q == PRIO_A);
    winB = bEligible && (!aEligible || prio_q == PRIO_B);
  end

  assign reqA.ready = winA;
  assign reqB.ready = winB;

  // Steer the winner's payload and classify what this edge does
  always_comb begin
    selRs1     = winB ? reqB.rs1  : reqA.rs1;
    selRs2     = winB ? reqB.rs2  : reqA.rs2;
    selRd      = winB ? reqB.rd   : reqA.rd;
    selFunc    = winB ? reqB.func : reqA.func;
    selAddr    = winB ? reqB.addr : reqA.addr;
    accept     = winA || winB;
    selIllegal = isIllegal(selFunc);
    issueNow   = accept && !selIllegal;
    stallNow   = (reqA.valid || reqB.valid) && !accept;
  end

  // Scoreboard update: a fresh issue loads its rd with WB_LAT, taking
  // precedence over that counter's own countdown; every other busy
  // counter ticks down by one.
  always_comb begin
    sbCnt_d = sbCnt_q;
    for (int i = 0; i < 16; i++) begin
      if (issueNow && selRd == 4'(i)) begin
        sbCnt_d[i] = LOAD_VAL;
      end else if (sbCnt_q[i] != 3'd0) begin
        sbCnt_d[i] = sbCnt_q[i] - 3'd1;
      end
    end
  end

  // Issue slot, error pulse, pointer and counters. The field registers
  // only move on a legal issue so downstream sees the last op held.
  always_comb begin
    issValid_d = issueNow;
    errFunc_d  = accept && selIllegal;
    issRs1_d   = issueNow ? selRs1  : issRs1_q;
    issRs2_d   = issueNow ? selRs2  : issRs2_q;
    issRd_d    = issueNow ? selRd   : issRd_q;
    issFunc_d  = issueNow ? selFunc : issFunc_q;
    issAddr_d  = issueNow ? selAddr : issAddr_q;
    issSrc_d   = issueNow ? winB    : issSrc_q;
    prio_d     = prio_q;
    if (accept) begin
      prio_d = winA ? PRIO_B : PRIO_A;
    end
    issueCnt_d = issueCnt_q + 16'(issueNow);
    stallCnt_d = stallCnt_q + 16'(stallNow);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk1_i) begin
    if (rst_i) begin
      sbCnt_q    <= '0;
      prio_q     <= PRIO_A;
      issValid_q <= 1'b0;
      issRs1_q   <= 4'd0;
      issRs2_q   <= 4'd0;
      issRd_q    <= 4'd0;
      issFunc_q  <= 4'd0;
      issAddr_q  <= 8'd0;
      issSrc_q   <= 1'b0;
      errFunc_q  <= 1'b0;
      issueCnt_q <= 16'd0;
      stallCnt_q <= 16'd0;
    end else begin
      sbCnt_q    <= sbCnt_d;
      prio_q     <= prio_d;
      issValid_q <= issValid_d;
      issRs1_q   <= issRs1_d;
      issRs2_q   <= issRs2_d;
      issRd_q    <= issRd_d;
      issFunc_q  <= issFunc_d;
      issAddr_q  <= issAddr_d;
      issSrc_q   <= issSrc_d;
      errFunc_q  <= errFunc_d;
      issueCnt_q <= issueCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign iss_valid_o = issValid_q;
  assign iss_rs1_o   = issRs1_q;
  assign iss_rs2_o   = issRs2_q;
  assign iss_rd_o    = issRd_q;
  assign iss_func_o  = issFunc_q;
  assign iss_addr_o  = issAddr_q;
  assign iss_src_o   = issSrc_q;
  assign err_func_o  = errFunc_q;
  assign issue_cnt_o = issueCnt_q;
  assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_pipe_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_pipe_issue_sched
//
// Self-checking bench for pipe_issue_sched. A reference model tracks, per
// register, the first edge at which a reader may issue, plus the round-robin
// pointer, issue slot contents and the two counters. Each scenario task
// drives ops through per-requester queues and compares the DUT to the model
// and to the fixed timing figures of the scheduler.
// ---------------------------------------------------------------------------
module tb_pipe_issue_sched;
  localparam int WB_LAT = 3;

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [3:0] func;
    logic [7:0] addr;
  } op_t;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        hold;
  logic        iss_valid, iss_src, err_func;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0]  iss_addr;
  logic [15:0] issue_cnt, stall_cnt;

  pipe_issue_sched_if reqA ();
  pipe_issue_sched_if reqB ();

  pipe_issue_sched #(.WB_LAT(WB_LAT)) dut (
    .clk1_i      (clk1),
    .rst_i       (rst),
    .hold_i      (hold),
    .reqA        (reqA),
    .reqB        (reqB),
    .iss_valid_o (iss_valid),
    .iss_rs1_o   (iss_rs1),
    .iss_rs2_o   (iss_rs2),
    .iss_rd_o    (iss_rd),
    .iss_func_o  (iss_func),
    .iss_addr_o  (iss_addr),
    .iss_src_o   (iss_src),
    .err_func_o  (err_func),
    .issue_cnt_o (issue_cnt),
    .stall_cnt_o (stall_cnt)
  );

  // Free-running pipeline clock
  always #5 clk1 = ~clk1;

  int compared = 0;
  int mismatched = 0;

  op_t qA[$];
  op_t qB[$];

  // Reference model state
  int          edgeNo = 0;
  int          freeAt[16];
  bit          mPrio = 1'b0;
  bit          mIssValid = 1'b0;
  bit          mSrc = 1'b0;
  bit          mErr = 1'b0;
  op_t         mOp = '0;
  logic [15:0] mIssueCnt = 16'd0;
  logic [15:0] mStallCnt = 16'd0;

  wire [26:0] dutOut = {iss_valid, iss_src, err_func, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr};

  function automatic logic [26:0] expOut();
    return {mIssValid, mSrc, mErr, mOp};
  endfunction

  // Source usage as listed for the ALU function codes
  function automatic bit readsRs1(logic [3:0] f);
    return (f < 4'd12) && !(f inside {4'd4, 4'd9});
  endfunction

  function automatic bit readsRs2(logic [3:0] f);
    return f inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
  endfunction

  function automatic op_t opA();
    return {reqA.rs1, reqA.rs2, reqA.rd, reqA.func, reqA.addr};
  endfunction

  function automatic op_t opB();
    return {reqB.rs1, reqB.rs2, reqB.rd, reqB.func, reqB.addr};
  endfunction

  // Can this op go at the upcoming edge (edgeNo)?
  function automatic bit canGo(logic v, op_t op);
    if (v !== 1'b1 || hold || rst) return 1'b0;
    if (op.func >= 4'd12) return 1'b1;
    if (readsRs1(op.func) && edgeNo < freeAt[op.rs1]) return 1'b0;
    if (readsRs2(op.func) && edgeNo < freeAt[op.rs2]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic predict(output bit pa, output bit pb);
    bit ea, eb;
    ea = canGo(reqA.valid, opA());
    eb = canGo(reqB.valid, opB());
    pa = ea && (!eb || !mPrio);
    pb = eb && (!ea || mPrio);
  endtask

  // Apply the scheduling rules for one rising edge
  task automatic modelEdge(input bit pa, input bit pb);
    op_t w;
    w = pb ? opB() : opA();
    if (rst) begin
      mPrio = 1'b0; mIssValid = 1'b0; mSrc = 1'b0; mErr = 1'b0; mOp = '0;
      mIssueCnt = 16'd0; mStallCnt = 16'd0;
      foreach (freeAt[i]) freeAt[i] = 0;
    end else if (pa || pb) begin
      mPrio = pa;
      mErr = (w.func >= 4'd12);
      mIssValid = !mErr;
      if (!mErr) begin
        mOp = w;
        mSrc = pb;
        mIssueCnt = mIssueCnt + 16'd1;
        freeAt[w.rd] = edgeNo + WB_LAT;
      end
    end else begin
      mIssValid = 1'b0;
      mErr = 1'b0;
      if (reqA.valid || reqB.valid) mStallCnt = mStallCnt + 16'd1;
    end
    edgeNo++;
  endtask

  task automatic applyStimulus();
    reqA.valid = (qA.size() > 0);
    if (qA.size() > 0) {reqA.rs1, reqA.rs2, reqA.rd, reqA.func, reqA.addr} = qA[0];
    reqB.valid = (qB.size() > 0);
    if (qB.size() > 0) {reqB.rs1, reqB.rs2, reqB.rd, reqB.func, reqB.addr} = qB[0];
  endtask

  task automatic advance(input bit pa, input bit pb);
    @(posedge clk1);
    modelEdge(pa, pb);
    if (pa) void'(qA.pop_front());
    if (pb) void'(qB.pop_front());
    #1;
    applyStimulus();
  endtask

  task automatic idleCycles(input int n);
    bit pa, pb;
    repeat (n) begin
      predict(pa, pb);
      advance(pa, pb);
    end
  endtask

  // Reset: ready stays low while rst is high, everything clears
  task automatic test_reset();
    bit pa, pb;
    rst = 1'b1; hold = 1'b0;
    qA.delete(); qB.delete();
    qA.push_back({4'd0, 4'd0, 4'd1, 4'd0, 8'h10});
    applyStimulus();
    for (int i = 0; i < 2; i++) begin
      predict(pa, pb);
      @(negedge clk1);
      compared++;
      if (reqA.ready !== 1'b0 || reqB.ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_ready: a_ready=%b b_ready=%b required 0/0", reqA.ready, reqB.ready);
      end
      advance(pa, pb);
    end
    compared++;
    if (dutOut !== 27'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h required 0", dutOut);
    end
    compared++;
    if (issue_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_counts: issue=%0d stall=%0d required 0/0", issue_cnt, stall_cnt);
    end
    qA.delete();
    rst = 1'b0;
    applyStimulus();
  endtask

  // Four independent ops from A issue on consecutive cycles
  task automatic test_independent_stream();
    bit pa, pb;
    logic [15:0] baseI, baseS;
    baseI = mIssueCnt; baseS = mStallCnt;
    for (int k = 1; k <= 4; k++) qA.push_back({4'd0, 4'd0, 4'(k), 4'd0, 8'(k * 16)});
    applyStimulus();
    for (int k = 1; k <= 4; k++) begin
      predict(pa, pb);
      @(negedge clk1);
      compared++;
      if (reqA.ready !== 1'b1 || reqB.ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL stream_ready[%0d]: a_ready=%b b_ready=%b required 1/0", k, reqA.ready, reqB.ready);
      end
      advance(pa, pb);
      compared++;
      if (iss_valid !== 1'b1 || iss_rd !== 4'(k) || dutOut !== expOut()) begin
        mismatched++;
        $display("[TB] FAIL stream_issue[%0d]: got %h required %h (rd %0d)", k, dutOut, expOut(), k);
      end
    end
    compared++;
    if (issue_cnt !== baseI + 16'd4 || stall_cnt !== baseS) begin
      mismatched++;
      $display("[TB] FAIL stream_counts: issue=%0d stall=%0d required %0d/%0d",
               issue_cnt, stall_cnt, baseI + 16'd4, baseS);
    end
  endtask

  // RAW hazard: the reader of r5 waits WB_LAT edges after the producer
  task automatic test_raw_stall();
    bit pa, pb;
    int e1, e2, n;
    logic [15:0] baseS;
    idleCycles(WB_LAT + 1);
    baseS = mStallCnt;
    e1 = -1; e2 = -1; n = 0;
    qA.push_back({4'd0, 4'd0, 4'd5, 4'd0, 8'h50});
    qA.push_back({4'd5, 4'd2, 4'd6, 4'd1, 8'h51});
    applyStimulus();
    while (qA.size() > 0 && n < 12) begin
      predict(pa, pb);
      @(negedge clk1);
      compared++;
      if (reqA.ready !== pa || reqB.ready !== pb) begin
        mismatched++;
        $display("[TB] FAIL raw_ready: a_ready=%b b_ready=%b required %b/%b", reqA.ready, reqB.ready, pa, pb);
      end
      if (reqA.ready === 1'b1) begin
        if (e1 < 0) e1 = edgeNo; else e2 = edgeNo;
      end
      advance(pa, pb);
      n++;
      compared++;
      if (dutOut !== expOut()) begin
        mismatched++;
        $display("[TB] FAIL raw_issue: got %h required %h", dutOut, expOut());
      end
    end
    compared++;
    if (qA.size() !== 0 || e2 - e1 !== WB_LAT) begin
      mismatched++;
      $display("[TB] FAIL raw_spacing: edges %0d..%0d gap %0d required %0d", e1, e2, e2 - e1, WB_LAT);
    end
    compared++;
    if (stall_cnt !== baseS + 16'(WB_LAT - 1)) begin
      mismatched++;
      $display("[TB] FAIL raw_stall_cnt: got %0d required %0d", stall_cnt, baseS + 16'(WB_LAT - 1));
    end
  endtask

  // Both sides continuously valid: sources alternate, never both ready
  task automatic test_round_robin();
    bit pa, pb;
    int issued, n;
    idleCycles(WB_LAT + 1);
    // A lone B issue leaves the pointer on A
    qB.push_back({4'd0, 4'd0, 4'd13, 4'd0, 8'hD0});
    applyStimulus();
    predict(pa, pb);
    @(negedge clk1);
    compared++;
    if (reqB.ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rr_prep: b_ready=%b required 1", reqB.ready);
    end
    advance(pa, pb);
    qA.push_back({4'd0, 4'd0, 4'd8, 4'd2, 8'hA0});
    qA.push_back({4'd0, 4'd0, 4'd9, 4'd5, 8'hA1});
    qB.push_back({4'd0, 4'd0, 4'd10, 4'd6, 8'hB0});
    qB.push_back({4'd0, 4'd0, 4'd11, 4'd7, 8'hB1});
    applyStimulus();
    issued = 0; n = 0;
    while ((qA.size() + qB.size()) > 0 && n < 12) begin
      predict(pa, pb);
      @(negedge clk1);
      compared++;
      if ((reqA.ready && reqB.ready) !== 1'b0 || reqA.ready !== pa || reqB.ready !== pb) begin
        mismatched++;
        $display("[TB] FAIL rr_ready: a_ready=%b b_ready=%b required %b/%b", reqA.ready, reqB.ready, pa, pb);
      end
      advance(pa, pb);
      n++;
      if (iss_valid === 1'b1) begin
        compared++;
        if (iss_src !== 1'(issued % 2) || dutOut !== expOut()) begin
          mismatched++;
          $display("[TB] FAIL rr_src[%0d]: src=%b out=%h required src=%b out=%h",
                   issued, iss_src, dutOut, 1'(issued % 2), expOut());
        end
        issued++;
      end
    end
    compared++;
    if (issued !== 4) begin
      mismatched++;
      $display("[TB] FAIL rr_count: issued %0d required 4", issued);
    end
  endtask

  // A blocked on r7 does not hold back an independent B op
  task automatic test_bypass();
    bit pa, pb;
    int wEdge, aEdge, bEdge, n;
    idleCycles(WB_LAT + 1);
    qB.push_back({4'd0, 4'd0, 4'd7, 4'd0, 8'h70});
    applyStimulus();
    predict(pa, pb);
    @(negedge clk1);
    wEdge = edgeNo;
    compared++;
    if (reqB.ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bypass_writer: b_ready=%b required 1", reqB.ready);
    end
    advance(pa, pb);
    qA.push_back({4'd7, 4'd0, 4'd14, 4'd3, 8'h71});
    qB.push_back({4'd1, 4'd2, 4'd12, 4'd4, 8'h72});
    applyStimulus();
    aEdge = -1; bEdge = -1; n = 0;
    while ((qA.size() + qB.size()) > 0 && n < 12) begin
      predict(pa, pb);
      @(negedge clk1);
      if (reqA.ready === 1'b1) aEdge = edgeNo;
      if (reqB.ready === 1'b1) bEdge = edgeNo;
      compared++;
      if (reqA.ready !== pa || reqB.ready !== pb) begin
        mismatched++;
        $display("[TB] FAIL bypass_ready: a_ready=%b b_ready=%b required %b/%b", reqA.ready, reqB.ready, pa, pb);
      end
      advance(pa, pb);
      n++;
    end
    compared++;
    if (bEdge !== wEdge + 1 || aEdge !== wEdge + WB_LAT) begin
      mismatched++;
      $display("[TB] FAIL bypass_timing: B at +%0d A at +%0d required +1 and +%0d",
               bEdge - wEdge, aEdge - wEdge, WB_LAT);
    end
  endtask

  // Illegal func from B is consumed and flagged, never issued
  task automatic test_illegal();
    bit pa, pb;
    logic [15:0] baseI;
    idleCycles(WB_LAT + 1);
    baseI = mIssueCnt;
    qB.push_back({4'd3, 4'd4, 4'd5, 4'd13, 8'hEE});
    applyStimulus();
    predict(pa, pb);
    @(negedge clk1);
    compared++;
    if (reqB.ready !== 1'b1 || reqA.ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL illegal_ready: a_ready=%b b_ready=%b required 0/1", reqA.ready, reqB.ready);
    end
    advance(pa, pb);
    compared++;
    if (err_func !== 1'b1 || iss_valid !== 1'b0 || issue_cnt !== baseI || dutOut !== expOut()) begin
      mismatched++;
      $display("[TB] FAIL illegal_flag: err=%b valid=%b issue=%0d out=%h required err=1 valid=0 issue=%0d out=%h",
               err_func, iss_valid, issue_cnt, dutOut, baseI, expOut());
    end
    idleCycles(1);
    compared++;
    if (err_func !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL illegal_pulse: err=%b required 0", err_func);
    end
  endtask

  // Mid-run reset clears a busy counter; hold blocks and counts stalls
  task automatic test_reset_hold();
    bit pa, pb;
    logic [15:0] baseS;
    idleCycles(WB_LAT + 1);
    qA.push_back({4'd0, 4'd0, 4'd3, 4'd0, 8'h30});
    applyStimulus();
    idleCycles(2);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    qA.push_back({4'd3, 4'd3, 4'd4, 4'd3, 8'h33});
    applyStimulus();
    predict(pa, pb);
    @(negedge clk1);
    compared++;
    if (reqA.ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_clear_ready: a_ready=%b required 1", reqA.ready);
    end
    advance(pa, pb);
    compared++;
    if (iss_valid !== 1'b1 || iss_rd !== 4'd4 || dutOut !== expOut()) begin
      mismatched++;
      $display("[TB] FAIL reset_clear_issue: got %h required %h", dutOut, expOut());
    end
    hold = 1'b1;
    baseS = mStallCnt;
    qA.push_back({4'd0, 4'd0, 4'd5, 4'd0, 8'h55});
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      predict(pa, pb);
      @(negedge clk1);
      compared++;
      if (reqA.ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold_ready[%0d]: a_ready=%b required 0", i, reqA.ready);
      end
      advance(pa, pb);
    end
    compared++;
    if (stall_cnt !== baseS + 16'd5) begin
      mismatched++;
      $display("[TB] FAIL hold_stall_cnt: got %0d required %0d", stall_cnt, baseS + 16'd5);
    end
    hold = 1'b0;
    idleCycles(1);
    compared++;
    if (iss_valid !== 1'b1 || iss_rd !== 4'd5) begin
      mismatched++;
      $display("[TB] FAIL hold_release: valid=%b rd=%0d required 1/5", iss_valid, iss_rd);
    end
  endtask

  // Random traffic with hazards, illegal codes, hold and rare resets
  task automatic test_random();
    bit pa, pb;
    for (int c = 0; c < 400; c++) begin
      if (qA.size() == 0 && $urandom_range(0, 2) == 0)
        qA.push_back({4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                      4'($urandom_range(0, 15)), 8'($urandom)});
      if (qB.size() == 0 && $urandom_range(0, 2) == 0)
        qB.push_back({4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                      4'($urandom_range(0, 15)), 8'($urandom)});
      hold = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus();
      predict(pa, pb);
      @(negedge clk1);
      compared++;
      if ((reqA.ready && reqB.ready) !== 1'b0 || reqA.ready !== pa || reqB.ready !== pb) begin
        mismatched++;
        $display("[TB] FAIL rand_ready[%0d]: a_ready=%b b_ready=%b required %b/%b", c, reqA.ready, reqB.ready, pa, pb);
      end
      advance(pa, pb);
      compared++;
      if (dutOut !== expOut() || issue_cnt !== mIssueCnt || stall_cnt !== mStallCnt) begin
        mismatched++;
        $display("[TB] FAIL rand_out[%0d]: out=%h issue=%0d stall=%0d required out=%h issue=%0d stall=%0d",
                 c, dutOut, issue_cnt, stall_cnt, expOut(), mIssueCnt, mStallCnt);
      end
    end
    rst = 1'b0;
    hold = 1'b0;
  endtask

  // Scenario sequence
  initial begin
    rst = 1'b1;
    hold = 1'b0;
    foreach (freeAt[i]) freeAt[i] = 0;
    reqA.valid = 1'b0; reqA.rs1 = '0; reqA.rs2 = '0; reqA.rd = '0; reqA.func = '0; reqA.addr = '0;
    reqB.valid = 1'b0; reqB.rs1 = '0; reqB.rs2 = '0; reqB.rd = '0; reqB.func = '0; reqB.addr = '0;
    $display("[TB] starting pipe_issue_sched bench, WB_LAT=%0d", WB_LAT);
    test_reset();
    test_independent_stream();
    test_raw_stall();
    test_round_robin();
    test_bypass();
    test_illegal();
    test_reset_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
